// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - access size and FSM state encodings plus alignment helpers
package dmem_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Size 11 behaves like a word everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lo[0];
      default:   return lo != 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] force_align(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return lo;
      SIZE_HALF: return {lo[1], 1'b0};
      default:   return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM stage load/store request/ack bus
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, size, sext, addr, wdata,
                  input  ready, ack, rdata, err);
  modport slave  (input  req, we, size, sext, addr, wdata,
                  output ready, ack, rdata, err);
endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - little-endian lane steering for stores and load extraction/extension
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] ldata
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rword >> {lane, 3'b000};
    be      = 4'b1111;
    wword   = wdata;
    ldata   = rword;
    case (size)
      SIZE_BYTE: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata[7:0]}};
        ldata = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        ldata = {{16{sext & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be    = 4'b1111;
        wword = wdata;
        ldata = rword;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder with wait states
// DMEM_ALIGN_CHECK_EN: report misaligned accesses via err instead of forcing alignment.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);

  state_t             state;
  logic [3:0]         cnt;
  logic               we_q;
  logic [1:0]         size_q;
  logic               sext_q;
  logic [ADDR_W+1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic               ready_q;
  logic               ack_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic               misalign;

  logic [31:0]        mem [DEPTH_WORDS];
  logic [ADDR_W-1:0]  word_idx;
  logic [31:0]        rword;
  logic [3:0]         be;
  logic [31:0]        wword;
  logic [31:0]        ldata;
  logic               wr_en;
  logic               unused_addr;

  assign unused_addr = &{1'b0, bus.addr[31:ADDR_W+2]};
  assign word_idx    = addr_q[ADDR_W+1:2];
  assign rword       = mem[word_idx];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = is_misaligned(size_q, addr_q[1:0]);
  assign bus.err  = err_q;
`else
  assign misalign = 1'b0;
  assign bus.err  = 1'b0;
`endif

  dmem_lane_align u_align (
    .size  (size_q),
    .sext  (sext_q),
    .lane  (addr_q[1:0]),
    .wdata (wdata_q),
    .rword (rword),
    .be    (be),
    .wword (wword),
    .ldata (ldata)
  );

  assign wr_en = (state == S_ACCESS) && we_q && !misalign;

  // Storage is deliberately not reset; an async reset forces state out of ACCESS.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      ready_q <= 1'b1;
      ack_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ack_q <= 1'b0;
          if (bus.req) begin
            we_q    <= bus.we;
            size_q  <= bus.size;
            sext_q  <= bus.sext;
            wdata_q <= bus.wdata;
`ifdef DMEM_ALIGN_CHECK_EN
            addr_q  <= bus.addr[ADDR_W+1:0];
`else
            addr_q  <= {bus.addr[ADDR_W+1:2], force_align(bus.size, bus.addr[1:0])};
`endif
            cnt     <= 4'(WAIT_STATES);
            ready_q <= 1'b0;
            state   <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (!we_q) rdata_q <= misalign ? 32'd0 : ldata;
          err_q <= misalign;
          ack_q <= 1'b1;
          state <= S_RESP;
        end
        S_RESP: begin
          ack_q   <= 1'b0;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder (WAIT_STATES=2)
module tb_dmem_responder;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_access(input logic w, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic e, output int lat);
    bit found;
    @(negedge clk);
    vectors++;
    if (bus.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_before_req: got %b expected 1", bus.ready);
    end
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sext = sx; bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    lat = -1; rd = 'x; e = 1'bx; found = 0;
    for (int n = 1; n <= 40 && !found; n++) begin
      @(negedge clk);
      if (bus.ack === 1'b1) begin
        lat = n; rd = bus.rdata; e = bus.err; found = 1;
      end
    end
    bus.req = 1'b0;
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    vectors += 4;
    if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
    if (bus.ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b expected 0", bus.ack); end
    if (bus.rdata !== 32'd0) begin miscompares++; $display("FAIL reset_rdata: got 0x%08h expected 0", bus.rdata); end
    if (bus.err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", bus.err); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic e; int lat;
    do_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, e, lat);
    chk32("store_latency", 32'(lat), 32'd4);
    do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, e, lat);
    chk32("load_latency", 32'(lat), 32'd4);
    chk32("lw_0x10", rd, 32'hDEADBEEF);
    chk32("lw_0x10_err", {31'd0, e}, 32'd0);
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic e; int lat;
    do_access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, e, lat);
    chk32("lb_0x13", rd, 32'hFFFFFFDE);
    do_access(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, e, lat);
    chk32("lbu_0x10", rd, 32'h000000EF);
    do_access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, e, lat);
    chk32("lh_0x12", rd, 32'hFFFFDEAD);
    do_access(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, rd, e, lat);
    chk32("lhu_0x10", rd, 32'h0000BEEF);
    repeat (3) @(negedge clk);
    chk32("rdata_hold", bus.rdata, 32'h0000BEEF);
  endtask

  task automatic test_partial_store();
    logic [31:0] rd; logic e; int lat;
    do_access(1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAAAA55, rd, e, lat);
    chk32("sb_keeps_rdata", rd, 32'h0000BEEF);
    do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, e, lat);
    chk32("lw_after_sb", rd, 32'hDEAD55EF);
    do_access(1'b0, 2'b10, 1'b0, 32'h410, 32'h0, rd, e, lat);
    chk32("lw_wrap_0x410", rd, 32'hDEAD55EF);
  endtask

  task automatic test_back_to_back();
    bit found; int gap; int ready_low; logic [31:0] rd2;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.sext = 1'b0;
    bus.addr = 32'h40; bus.wdata = 32'hA5A51234;
    found = 0;
    for (int n = 1; n <= 40 && !found; n++) begin
      @(negedge clk);
      if (bus.ack === 1'b1) found = 1;
    end
    chk32("b2b_first_ack", {31'd0, found}, 32'd1);
    bus.we = 1'b0; bus.wdata = 32'h0;
    gap = -1; ready_low = 0; rd2 = 'x; found = 0;
    for (int k = 1; k <= 12 && !found; k++) begin
      @(negedge clk);
      if (k == 1) chk32("b2b_ready_after_ack", {31'd0, bus.ready}, 32'd1);
      if (bus.ready !== 1'b1) ready_low++;
      if (bus.ack === 1'b1) begin gap = k; rd2 = bus.rdata; found = 1; end
    end
    bus.req = 1'b0;
    chk32("b2b_ack_gap", 32'(gap), 32'd5);
    chk32("b2b_ready_low", 32'(ready_low), 32'd4);
    chk32("b2b_load", rd2, 32'hA5A51234);
    @(negedge clk);
    chk32("ack_single_cycle", {31'd0, bus.ack}, 32'd0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic e; int lat; int acks;
    do_access(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, rd, e, lat);
    do_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, e, lat);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.addr = 32'h20; bus.wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; bus.req = 1'b0;
    #1;
    chk32("midrst_ready", {31'd0, bus.ready}, 32'd1);
    chk32("midrst_rdata", bus.rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    acks = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (bus.ack === 1'b1) acks++;
    end
    chk32("midrst_no_ack", 32'(acks), 32'd0);
    do_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, e, lat);
    chk32("midrst_old_contents", rd, 32'hCAFEF00D);
  endtask

  task automatic test_align();
    logic [31:0] rd; logic e; int lat;
    do_access(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, rd, e, lat);
    chk32("misalign_latency", 32'(lat), 32'd4);
`ifdef DMEM_ALIGN_CHECK_EN
    chk32("lw_0x22_rdata", rd, 32'd0);
    chk32("lw_0x22_err", {31'd0, e}, 32'd1);
    do_access(1'b1, 2'b01, 1'b0, 32'h21, 32'h0000FFFF, rd, e, lat);
    chk32("sh_0x21_err", {31'd0, e}, 32'd1);
    do_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, e, lat);
    chk32("lw_0x20_unchanged", rd, 32'hCAFEF00D);
    chk32("lw_0x20_err", {31'd0, e}, 32'd0);
`else
    chk32("lw_0x22_rdata", rd, 32'hCAFEF00D);
    chk32("lw_0x22_err", {31'd0, e}, 32'd0);
    do_access(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, rd, e, lat);
    chk32("lhu_0x11_forced", rd, 32'h000055EF);
    chk32("lhu_0x11_err", {31'd0, e}, 32'd0);
`endif
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sext = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    test_word();
    test_subword();
    test_partial_store();
    test_back_to_back();
    test_reset_mid();
    test_align();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
